sisc_fetch: RTL and testbench
=============================

# sisc_fetch

Instruction fetch unit for the SISC processor: owns the program counter, issues word reads to instruction memory over a ready-based handshake, and drives the 32-bit `instruction` word into the SISC datapath/control. It is the supplying end of the instruction interface that `sisc` consumes. It holds each fetched word stable until control acknowledges it, then advances the PC sequentially or to a branch target.

## Interface

**Parameters**

- `AW`, default 16: PC and instruction-memory address width, in words.
- `RESET_PC`, default 0: PC value loaded on reset.

**Ports**

- `clk` input 1: clock; all state updates on the rising edge.
- `rst_f` input 1: reset, asynchronous, active-high.
- `pc_en` input 1: fetch enable from control. The FSM leaves IDLE only while this is 1.
- `imem_req` output 1: read request to instruction memory.
- `imem_addr` output AW: word address of the read; equals `pc`.
- `imem_rdata` input 32: read data; valid in any cycle where `imem_ready`=1.
- `imem_ready` input 1: read completes this cycle; may be combinational from `imem_req`.
- `instruction` output 32: fetched instruction register (IR), feeding the datapath.
- `instr_valid` output 1: IR holds an unconsumed instruction.
- `instr_ack` input 1: control has finished with the current instruction.
- `br_taken` input 1: on ack, load the branch target instead of `pc+1`.
- `br_abs` input 1: 0 selects a PC-relative target; 1 selects an absolute target.
- `br_imm` input 16: branch immediate (`instruction[15:0]` of the branch).
- `pc` output AW: address of the instruction in IR, or of the fetch in progress.

## Operation

- The FSM has three states: IDLE, FETCH, HOLD.
- **IDLE:**
  - `imem_req`=0 and `instr_valid`=0.
  - If `pc_en`=1, go to FETCH on the next edge.
- **FETCH:**
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until `imem_ready`.
  - On `imem_ready`=1: IR←`imem_rdata`, go to HOLD.
  - Dropping `pc_en` during FETCH does not abort; the read completes normally.
- **HOLD:**
  - `instr_valid`=1. IR and `pc` are frozen.
  - On `instr_ack`=1: `pc` ← next PC. Then go to FETCH if `pc_en`=1, else IDLE.
- **Next-PC arithmetic** (all results truncated mod 2^AW, so wrap-around is silent):
  - `br_taken`=0: `pc+1`.
  - `br_taken`=1, `br_abs`=0: `pc + 1 + sign_extend(br_imm)`.
  - `br_taken`=1, `br_abs`=1: `br_imm` zero-extended or truncated to AW bits.
- `br_taken`, `br_abs` and `br_imm` are sampled only in HOLD with `instr_ack`=1; at all other times they are ignored.
- `instr_ack` outside HOLD is ignored.
- `imem_ready` outside FETCH is ignored, including a stale completion arriving after reset.
- At most one memory read is outstanding. There are no speculative fetches.
- IR is not cleared on ack. It keeps the old word until the next capture; consumers qualify it with `instr_valid`.

## Timing

- **Reset (asynchronous, immediate):**
  - state=IDLE, `pc`=RESET_PC, `instruction`=32'h0.
  - `instr_valid`=0, `imem_req`=0, `imem_addr`=RESET_PC.
- **Reset mid-operation:** asserting `rst_f` in FETCH drops `imem_req` in the same cycle. Asserting it in HOLD discards IR.
- **Fetch latency:**
  - Request to valid: `imem_ready` in cycle N of FETCH gives `instr_valid`=1 from cycle N+1.
  - Zero-wait memory: `pc_en` high at edge E gives `imem_req` after E, and `instr_valid` one edge later.
- **Ack to next request:** `instr_ack` at edge E drops `instr_valid` and updates `pc` after E. If `pc_en`=1, `imem_req` is asserted in that same cycle.
- **Throughput:** with zero-wait memory and ack asserted in the first HOLD cycle, one instruction per 2 cycles.
- **Output stability:**
  - `imem_addr` must not change while `imem_req`=1 and `imem_ready`=0.
  - `instruction` must not change while `instr_valid`=1.
- **Simultaneous events:**
  - `instr_ack` with `pc_en`=0: the PC still advances, then the FSM idles.
  - `pc_en` rising in the same cycle as reset deassertion: the FSM enters FETCH on the first edge after reset deasserts.

## Test plan

- **Reset:** assert `rst_f` with `clk` stopped → all outputs at reset values; `pc`=RESET_PC=0 immediately, `imem_req`=0.
- **Sequential fetch, zero-wait memory:** `pc_en`=1, ack every HOLD → addresses 0,1,2,3; `instruction` matches memory words; `instr_valid` high every other cycle.
- **Wait states:** `imem_ready` delayed 3 cycles → `imem_req`=1 and `imem_addr` stable for 4 cycles; IR captured exactly on the ready cycle.
- **Branches:**
  - At `pc`=5, `br_taken`=1, `br_abs`=0, `br_imm`=16'hFFFD → next `imem_addr`=3.
  - `br_abs`=1, `br_imm`=16'h0040 → next `imem_addr`=16'h0040.
  - Relative from `pc`=16'hFFFF with `br_imm`=0 → wraps to 0.
- **Hold/back-pressure:** withhold `instr_ack` 5 cycles → `instruction`, `pc`, `instr_valid`=1 unchanged. Ack with `pc_en`=0 → IDLE with `pc` advanced by 1 and `imem_req`=0.
- **Reset mid-FETCH:** assert `rst_f` while waiting on `imem_ready` → `imem_req` drops the same cycle. A late `imem_ready` after release is ignored; the first new fetch is at address 0.

Source files
------------

// File: rtl/sisc_fetch.sv
// SISC instruction fetch: owns the PC, reads one word at a time from instruction
// memory, and holds it in IR until control acknowledges it.
module sisc_fetch #(
  parameter int AW       = 16,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          pc_en,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_ready,
  output logic [31:0]   instruction,
  output logic          instr_valid,
  input  logic          instr_ack,
  input  logic          br_taken,
  input  logic          br_abs,
  input  logic [15:0]   br_imm,
  output logic [AW-1:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [AW-1:0] RESET_PC_W = AW'(RESET_PC);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;

  logic [AW-1:0] imm_sx;
  logic [AW-1:0] imm_zx;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_next;

  // Immediate widened (or truncated) to AW bits, both signed and unsigned.
  always_comb begin
    imm_sx = '0;
    imm_zx = '0;
    for (int i = 0; i < AW; i++) begin
      imm_sx[i] = (i < 16) ? br_imm[i[3:0]] : br_imm[15];
      imm_zx[i] = (i < 16) ? br_imm[i[3:0]] : 1'b0;
    end
  end

  assign pc_inc = pc_q + AW'(1);

  always_comb begin
    pc_next = pc_inc;
    if (br_taken) begin
      pc_next = br_abs ? imm_zx : (pc_inc + imm_sx);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE: begin
        if (pc_en) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ack) begin
          pc_d    = pc_next;
          state_d = pc_en ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC_W;
      ir_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs decode straight from state so reset drops them immediately.
  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_HOLD);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed bench for sisc_fetch; memory returns {16'hC0DE, address} for every word.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst_f = 1'b0;
  logic        pc_en = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic        br_taken = 1'b0;
  logic        br_abs = 1'b0;
  logic [15:0] br_imm = 16'h0;
  logic [15:0] pc;

  logic        zero_wait = 1'b1;
  logic        rdy_man = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 if (clk_run) clk = ~clk;

  assign imem_rdata = {16'hC0DE, imem_addr};
  assign imem_ready = zero_wait ? imem_req : rdy_man;

  sisc_fetch #(.AW(16), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .pc_en       (pc_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .br_taken    (br_taken),
    .br_abs      (br_abs),
    .br_imm      (br_imm),
    .pc          (pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with the clock stopped.
    #3 rst_f = 1'b1;
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_ir", instruction, 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    clk_run = 1'b1;
    step();
    step();

    // pc_en rises together with reset release.
    rst_f     = 1'b0;
    pc_en     = 1'b1;
    instr_ack = 1'b1;

    // Zero-wait sequential fetch, ack held high (ignored while fetching).
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_req", 32'(imem_req), 32'h1);
      chk("seq_addr", 32'(imem_addr), 32'(i));
      chk("seq_vld_lo", 32'(instr_valid), 32'h0);
      step();
      chk("seq_vld_hi", 32'(instr_valid), 32'h1);
      chk("seq_ir", instruction, 32'hC0DE0000 + 32'(i));
      chk("seq_pc", 32'(pc), 32'(i));
    end

    // Wait states: ready arrives in the fourth FETCH cycle.
    zero_wait = 1'b0;
    rdy_man   = 1'b0;
    step();
    instr_ack = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step();
      chk("ws_req", 32'(imem_req), 32'h1);
      chk("ws_addr", 32'(imem_addr), 32'h4);
      chk("ws_vld", 32'(instr_valid), 32'h0);
      chk("ws_ir_old", instruction, 32'hC0DE0003);
    end
    rdy_man = 1'b1;
    step();
    rdy_man = 1'b0;
    chk("ws_vld_hi", 32'(instr_valid), 32'h1);
    chk("ws_ir", instruction, 32'hC0DE0004);

    // Back-pressure: no ack for 5 cycles.
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_vld", 32'(instr_valid), 32'h1);
      chk("hold_ir", instruction, 32'hC0DE0004);
      chk("hold_pc", 32'(pc), 32'h4);
      chk("hold_req", 32'(imem_req), 32'h0);
    end

    // Ack with pc_en low: PC advances, FSM idles.
    pc_en     = 1'b0;
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    chk("idle_req", 32'(imem_req), 32'h0);
    chk("idle_vld", 32'(instr_valid), 32'h0);
    chk("idle_pc", 32'(pc), 32'h5);
    step();
    chk("idle_stay", 32'(imem_req), 32'h0);

    zero_wait = 1'b1;
    pc_en     = 1'b1;
    step();
    chk("resume_addr", 32'(imem_addr), 32'h5);
    step();
    chk("resume_ir", instruction, 32'hC0DE0005);

    // Relative branch back: 5 + 1 - 3 = 3.
    instr_ack = 1'b1;
    br_taken  = 1'b1;
    br_abs    = 1'b0;
    br_imm    = 16'hFFFD;
    step();
    chk("br_rel_addr", 32'(imem_addr), 32'h3);
    chk("br_rel_req", 32'(imem_req), 32'h1);
    br_abs = 1'b1;
    br_imm = 16'h0040;
    step();
    chk("br_rel_ir", instruction, 32'hC0DE0003);
    chk("br_rel_pc", 32'(pc), 32'h3);

    // Absolute branch to 0x0040.
    step();
    chk("br_abs_addr", 32'(imem_addr), 32'h40);
    br_imm = 16'hFFFF;
    step();
    chk("br_abs_ir", instruction, 32'hC0DE0040);

    // Absolute to 0xFFFF, then relative with imm 0 wraps to 0.
    step();
    chk("br_ffff_addr", 32'(imem_addr), 32'hFFFF);
    br_abs = 1'b0;
    br_imm = 16'h0000;
    step();
    chk("br_ffff_ir", instruction, 32'hC0DEFFFF);
    step();
    chk("wrap_addr", 32'(imem_addr), 32'h0);
    br_taken = 1'b0;
    step();
    chk("wrap_ir", instruction, 32'hC0DE0000);

    // Reset while waiting on a slow read.
    zero_wait = 1'b0;
    rdy_man   = 1'b0;
    step();
    instr_ack = 1'b0;
    chk("mid_req", 32'(imem_req), 32'h1);
    chk("mid_addr", 32'(imem_addr), 32'h1);
    step();
    rst_f = 1'b1;
    pc_en = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'h0);
    chk("mid_rst_pc", 32'(pc), 32'h0);
    chk("mid_rst_ir", instruction, 32'h0);
    step();
    rst_f   = 1'b0;
    rdy_man = 1'b1;
    step();
    chk("stale_req", 32'(imem_req), 32'h0);
    chk("stale_vld", 32'(instr_valid), 32'h0);
    chk("stale_ir", instruction, 32'h0);
    rdy_man   = 1'b0;
    zero_wait = 1'b1;
    pc_en     = 1'b1;
    step();
    chk("post_addr", 32'(imem_addr), 32'h0);
    chk("post_req", 32'(imem_req), 32'h1);
    step();
    chk("post_ir", instruction, 32'hC0DE0000);
    chk("post_vld", 32'(instr_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
